// File: rtl/mux_scan_pkg.sv
// Shared types and defaults for the mux scan controller.
package mux_scan_pkg;

  localparam int SEL_W_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dwell_timer.sv
// Counts 0..DWELL-1 while enabled; tick marks the last cycle of each dwell window.
module dwell_timer #(
  parameter int DWELL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  assign tick = (cnt_q == CNT_LAST);

  // Next count: clear wins, wrap to zero after the last dwell cycle
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (en) begin
      if (tick) begin
        cnt_d = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Walks the mux select through every input, samples one bit per select after a
// settling dwell, and presents the rebuilt word on a valid/ready handshake.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF,
  parameter int DWELL = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    mux_bit_i,
  output logic [SEL_W-1:0]        sel_o,
  output logic                    busy,
  output logic [(2**SEL_W)-1:0]   data_o,
  output logic                    valid_o,
  input  logic                    ready_i
);

  localparam int N = 2**SEL_W;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N - 1);

  state_e           state_d, state_q;
  logic [SEL_W-1:0] sel_d, sel_q;
  logic [N-1:0]     shadow_d, shadow_q;
  logic [N-1:0]     data_d, data_q;
  logic             valid_d, valid_q;
  logic             busy_d, busy_q;
  logic             tick_s;
  logic             timer_en_s;
  logic             timer_clr_s;

  // Timer only runs in SCAN and restarts from zero on every entry into SCAN
  assign timer_en_s  = (state_q == ST_SCAN);
  assign timer_clr_s = !timer_en_s || abort;

  dwell_timer #(.DWELL(DWELL)) u_dwell_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (timer_clr_s),
    .en    (timer_en_s),
    .tick  (tick_s)
  );

  // Scan sequencing, bit capture and output handshake
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = valid_q;
    case (state_q)
      ST_IDLE: begin
        sel_d = {SEL_W{1'b0}};
        if (start) begin
          state_d = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        // abort beats a coincident final sample
        if (abort) begin
          state_d  = ST_IDLE;
          sel_d    = {SEL_W{1'b0}};
          shadow_d = {N{1'b0}};
        end else if (tick_s) begin
          shadow_d[sel_q] = mux_bit_i;
          if (sel_q == SEL_LAST) begin
            data_d  = shadow_d;
            valid_d = 1'b1;
            sel_d   = {SEL_W{1'b0}};
            state_d = ST_DONE;
          end else begin
            sel_d = sel_q + SEL_W'(1);
          end
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_DONE: begin
        if (valid_q && ready_i) begin
          valid_d = 1'b0;
          if (start) begin
            state_d = ST_SCAN;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        sel_d    = {SEL_W{1'b0}};
        shadow_d = {N{1'b0}};
        valid_d  = 1'b0;
      end
    endcase
    busy_d = (state_d == ST_SCAN);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= {SEL_W{1'b0}};
      shadow_q <= {N{1'b0}};
      data_q   <= {N{1'b0}};
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign sel_o   = sel_q;
  assign busy    = busy_q;
  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule
